// File: rtl/seq_right_shifter_pkg.sv
// Shared definitions for the shifter unit: default widths and the right-shifter state encoding.
package seq_right_shifter_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int MAG_W_DEF = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/seq_right_shifter_rshift1.sv
// Combinational one-place right shift; the vacated MSB takes the fill bit.
module seq_right_shifter_rshift1 #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] din,
    input  logic             fill,
    output logic [WIDTH-1:0] dout
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_bit
            assign dout[gi] = din[gi+1];
        end
    endgenerate

    assign dout[WIDTH-1] = fill;

endmodule

// File: rtl/seq_right_shifter.sv
// Iterative right shifter: one place per clock, logical or arithmetic, start/busy/done handshake.
module seq_right_shifter
    import seq_right_shifter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int MAG_W = MAG_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [MAG_W-1:0] mag,
    input  logic             arith,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q
);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] work_reg, work_next;
    logic [MAG_W-1:0] cnt_reg, cnt_next;
    logic             mode_reg, mode_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic [WIDTH-1:0] shifted;
    logic             fill;

    assign fill = mode_reg & work_reg[WIDTH-1];

    seq_right_shifter_rshift1 #(.WIDTH(WIDTH)) u_rshift1 (
        .din  (work_reg),
        .fill (fill),
        .dout (shifted)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            work_reg  <= '0;
            cnt_reg   <= '0;
            mode_reg  <= 1'b0;
            q_reg     <= '0;
        end else begin
            state_reg <= state_next;
            work_reg  <= work_next;
            cnt_reg   <= cnt_next;
            mode_reg  <= mode_next;
            q_reg     <= q_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        work_next  = work_reg;
        cnt_next   = cnt_reg;
        mode_next  = mode_reg;
        q_next     = q_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    work_next = A;
                    cnt_next  = mag;
                    mode_next = arith;
                    if (mag == '0) begin
                        // Zero-place request completes straight away with the operand unchanged.
                        q_next     = A;
                        state_next = S_DONE;
                    end else begin
                        state_next = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                work_next = shifted;
                cnt_next  = cnt_reg - MAG_W'(1);
                if (cnt_reg == MAG_W'(1)) begin
                    q_next     = shifted;
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign busy = (state_reg == S_SHIFT);
    assign done = (state_reg == S_DONE);
    assign Q    = q_reg;

endmodule

// File: tb/tb_seq_right_shifter.sv
// Directed bench for seq_right_shifter with a result scoreboard and latency/busy checks.
module tb_seq_right_shifter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] A;
    logic [3:0]  mag;
    logic        arith;
    logic        busy;
    logic        done;
    logic [15:0] Q;

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_queue[$];

    seq_right_shifter dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .mag   (mag),
        .arith (arith),
        .busy  (busy),
        .done  (done),
        .Q     (Q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Caller is positioned just after a falling edge with the DUT idle.
    task automatic do_req(input logic [15:0] a, input logic [3:0] m, input logic ar,
                          input int dup_at, input bit junk_in_done);
        int          cyc;
        int          busy_cnt;
        bit          seen;
        bit          q_moved;
        logic [15:0] exp_q;
        logic [15:0] q_before;
        start = 1'b1;
        A     = a;
        mag   = m;
        arith = ar;
        if (ar) exp_q = $signed(a) >>> m;
        else    exp_q = a >> m;
        exp_queue.push_back(exp_q);
        q_before = Q;
        cyc      = 0;
        busy_cnt = 0;
        seen     = 0;
        q_moved  = 0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                start = 1'b0;
                A     = 16'($urandom);
                mag   = 4'($urandom);
                arith = 1'($urandom);
            end
            if (dup_at != 0 && cyc == dup_at) begin
                start = 1'b1;
                A     = 16'hFFFF;
                mag   = 4'h1;
            end else if (dup_at != 0 && cyc == dup_at + 1) begin
                start = 1'b0;
            end
            if (done) begin
                seen = 1;
            end else begin
                if (busy) busy_cnt++;
                if (Q !== q_before) q_moved = 1;
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        check("latency", 32'(cyc), 32'(m) + 32'd1);
        check("busy_cycles", 32'(busy_cnt), 32'(m));
        check("busy_in_done", 32'(busy), 32'd0);
        check("q_stable_while_busy", 32'(q_moved), 32'd0);
        if (exp_queue.size() > 0) check("q_result", 32'(Q), 32'(exp_queue.pop_front()));
        else check("scoreboard_empty", 32'd0, 32'd1);
        $display("req A=%h mag=%0d arith=%0d -> Q=%h latency=%0d busy=%0d",
                 a, m, ar, Q, cyc, busy_cnt);
        if (junk_in_done) begin
            start = 1'b1;
            A     = 16'hFFFF;
            mag   = 4'h0;
            arith = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("restart_in_done_done", 32'(done), 32'd0);
            check("restart_in_done_busy", 32'(busy), 32'd0);
            check("restart_in_done_q", 32'(Q), 32'(exp_q));
            $display("start during done ignored, Q=%h", Q);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        A     = 16'h0;
        mag   = 4'h0;
        arith = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_q", 32'(Q), 32'h0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("idle_hold", {done, busy, 14'h0, Q}, 32'h0);
        end
        $display("reset: Q=%h busy=%0d done=%0d", Q, busy, done);

        for (int m = 0; m < 16; m++) begin
            @(negedge clk);
            do_req(16'h8000, 4'(m), 1'b0, 0, 1'b0);
        end

        @(negedge clk);
        do_req(16'h8000, 4'hF, 1'b1, 0, 1'b0);
        check("arith_8000_15", 32'(Q), 32'h0000FFFF);
        @(negedge clk);
        do_req(16'hF0F0, 4'h4, 1'b1, 0, 1'b0);
        check("arith_f0f0_4", 32'(Q), 32'h0000FF0F);
        @(negedge clk);
        do_req(16'h7FFF, 4'h3, 1'b1, 0, 1'b0);
        check("arith_7fff_3", 32'(Q), 32'h00000FFF);

        @(negedge clk);
        do_req(16'h1111, 4'h5, 1'b0, 2, 1'b0);
        check("ignored_second_start", 32'(Q), 32'h00000088);
        repeat (5) begin
            @(negedge clk);
            check("q_hold", {done, busy, 14'h0, Q}, 32'h00000088);
        end

        // Abort a long shift with reset four cycles after start.
        start = 1'b1;
        A     = 16'h0101;
        mag   = 4'hA;
        arith = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_q", 32'(Q), 32'h0);
        check("abort_busy", 32'(busy), 32'd0);
        begin
            bit saw_done;
            saw_done = 0;
            repeat (12) begin
                if (done) saw_done = 1;
                @(negedge clk);
            end
            check("abort_no_done", 32'(saw_done), 32'd0);
        end
        $display("reset mid-shift: Q=%h busy=%0d", Q, busy);
        do_req(16'h0101, 4'h5, 1'b0, 0, 1'b0);
        check("after_abort_q", 32'(Q), 32'h00000008);

        @(negedge clk);
        do_req(16'h1234, 4'h3, 1'b0, 0, 1'b1);
        do_req(16'hABCD, 4'h2, 1'b1, 0, 1'b0);
        check("back_to_back_q", 32'(Q), 32'h0000EAF3);

        check("scoreboard_drained", 32'(exp_queue.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
